// File: rtl/cdc_sched_pkg.sv
// Shared definitions for the CDC transmit scheduler slice.
//   - sched_state_t : scheduler FSM encoding (IDLE/SETUP/HOLD/GAP)
//   - clog2/id_width : sizing helpers for indices and counters
//   - DEFAULT_HOLD/DEFAULT_GAP : default enable high/low lengths
package cdc_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } sched_state_t;

  localparam int DEFAULT_HOLD = 3;
  localparam int DEFAULT_GAP  = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index/counter width that never collapses to zero bits.
  function automatic int id_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/cdc_rr_arbiter.sv
// Requester arbiter for cdc_tx_scheduler.
// Build option: CDC_ARB_RR_EN defined -> round-robin starting at an internal
// pointer that advances past each winner; undefined -> fixed priority,
// lowest index wins, no pointer state.
// Ports:
//   CLK, RST     : source clock, asynchronous active-low reset
//   req [NREQ]   : request vector
//   advance      : a grant was accepted this cycle
//   grant [NREQ] : one-hot grant (all zero when nothing requests)
//   index        : binary index of the granted requester
module cdc_rr_arbiter
  import cdc_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req,
  input  logic                      advance,
  output logic [NREQ-1:0]           grant,
  output logic [id_width(NREQ)-1:0] index
);

  localparam int IDW = id_width(NREQ);

  logic found;

`ifdef CDC_ARB_RR_EN
  logic [IDW-1:0] ptr;

  // Pointer moves only on an accept, to the slot just past the winner.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(index) == NREQ - 1) ? '0 : IDW'(int'(index) + 1);
    end
  end

  // Two passes avoid a variable rotate: first search from the pointer
  // upward, then wrap around from index 0.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDW'(i);
      end
    end
  end
`else
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{CLK, RST, advance};

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/cdc_tx_scheduler.sv
// Source-domain scheduler feeding a bus-enable data synchronizer.
// Arbitrates NREQ requesters, captures the winner's word onto unsync_bus and
// sequences bus_enable as SETUP(low 1) -> HOLD(high HOLD) -> GAP(low GAP) so
// the destination sees one clean rising edge per word with stable data.
// Build option: CDC_ARB_RR_EN selects round-robin arbitration (default build
// uses fixed lowest-index priority); timing is identical in both builds.
// Ports:
//   CLK, RST    : source clock, asynchronous active-low reset
//   req_valid   : per-requester word available
//   req_data    : packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready   : one-hot accept, only asserted in IDLE
//   unsync_bus  : registered captured word toward the synchronizer
//   bus_enable  : registered enable level toward the synchronizer
//   grant_id    : index of the last accepted requester
//   busy        : high whenever the FSM is not IDLE
module cdc_tx_scheduler
  import cdc_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int HOLD  = DEFAULT_HOLD,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          unsync_bus,
  output logic                      bus_enable,
  output logic [id_width(NREQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = id_width(((HOLD > GAP) ? HOLD : GAP) + 1);

  sched_state_t   state;
  sched_state_t   next_state;
  logic [CW-1:0]  cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           accept;
  logic [WIDTH-1:0] sel_word;

  cdc_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req_valid),
    .advance(accept),
    .grant  (grant),
    .index  (grant_idx)
  );

  // One-hot grant selects the captured word without a variable part-select.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = grant;
        if (|req_valid) begin
          accept     = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP: next_state = S_HOLD;
      S_HOLD:  if (cnt == '0) next_state = S_GAP;
      S_GAP:   if (cnt == '0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= next_state;
  end

  // Loaded on entry to HOLD and to GAP; the phase ends when it reads zero,
  // so a length of 1 loads 0 and lasts exactly one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (state == S_SETUP) begin
      cnt <= CW'(HOLD - 1);
    end else if ((state == S_HOLD) && (cnt == '0)) begin
      cnt <= CW'(GAP - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // bus_enable is registered from the next state so it is a clean flop
  // output; the word is only replaced on an accept, freezing it through GAP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus_enable <= 1'b0;
      unsync_bus <= '0;
      grant_id   <= '0;
    end else begin
      bus_enable <= (next_state == S_HOLD);
      if (accept) begin
        unsync_bus <= sel_word;
        grant_id   <= grant_idx;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/cdc_tx_scheduler.md
Name: cdc_tx_scheduler

Overview:
- Source-domain controller that feeds the team's bus-enable data synchronizer, which samples data on an enable edge.
- Arbitrates between NREQ requesters and captures the winner's word onto unsync_bus.
- Sequences bus_enable so the destination synchronizer sees one clean rising edge per word, with data held stable throughout.
- Sits in the source clock domain, one instance per synchronized bus (e.g. register-file read data / UART RX data toward the system clock).

Parameters:
- WIDTH, 8, data word width; matches the synchronizer bus width.
- NREQ, 2, number of requesters (>=1).
- HOLD, 3, source cycles bus_enable is held high (>=1); sized by the integrator for destination N stages and clock ratio.
- GAP, 3, source cycles bus_enable is held low after HOLD, before the next word (>=1).

Ports:
- CLK  in  1  source-domain clock.
- RST  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word available.
- req_data  in  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept; the transfer occurs on the edge where req_valid[i] && req_ready[i].
- unsync_bus  out  WIDTH  registered captured word, to the synchronizer.
- bus_enable  out  1  registered enable level, to the synchronizer.
- grant_id  out  clog2(NREQ) (min 1)  index of the last accepted requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low; applies any time, including mid-transfer; no completion of an in-flight word):
  - unsync_bus = 0, bus_enable = 0, grant_id = 0, busy = 0.
  - State = IDLE, round-robin pointer = 0, counter = 0.
- FSM states: IDLE, SETUP, HOLD, GAP.
- IDLE:
  - req_ready is combinational: one-hot grant if any req_valid, else all zero.
  - On accept edge: unsync_bus <= winner's word, grant_id <= winner index, go to SETUP.
  - No valid: stay in IDLE with outputs unchanged; unsync_bus keeps its last value.
- SETUP: 1 cycle, bus_enable = 0. Guarantees data is stable one cycle before the enable edge. Then go to HOLD.
- HOLD: bus_enable = 1 for exactly HOLD cycles. Counter loads HOLD-1 on entry and decrements; go to GAP at 0.
- GAP: bus_enable = 0 for exactly GAP cycles, then go to IDLE.
- Data stability: unsync_bus is frozen from SETUP through the end of GAP.
- Per-word occupancy is 2+HOLD+GAP cycles, counting the IDLE accept cycle; back-to-back throughput is one word per 2+HOLD+GAP cycles.
- req_ready is 0 in SETUP, HOLD and GAP. Requesters must hold req_valid and req_data until accepted.
- bus_enable and unsync_bus are flop outputs only; no combinational path from inputs to them.
- Arbitration: round-robin.
  - Search starts at the pointer; first valid wins.
  - After an accept, pointer <= winner+1, wrapping NREQ-1 -> 0.
  - A requester that drops valid before being granted loses nothing; the pointer does not move without an accept.
- Counter width is clog2(max(HOLD,GAP)+1); HOLD=1 and GAP=1 must work. NREQ=1 degenerates to a pass-through sequencer.

Optional Feature:
- CDC_ARB_RR_EN defined: round-robin arbitration as above.
- CDC_ARB_RR_EN not defined: fixed priority, lowest index wins; pointer logic removed.
- grant_id and all timing are identical in both builds.

Decomposition:
- Package cdc_sched_pkg holds:
  - state encoding (IDLE=2'd0, SETUP=2'd1, HOLD=2'd2, GAP=2'd3).
  - clog2 helper function.
  - default HOLD/GAP constants.
- One sub-module, cdc_rr_arbiter (NREQ): inputs req, advance, CLK, RST; outputs one-hot grant and index. It contains the pointer and the CDC_ARB_RR_EN switch. FSM, counter and capture registers stay in cdc_tx_scheduler.

Test Plan:
- Single word: reset, req_valid=01, req_data[7:0]=0xA5.
  - req_ready[0]=1 in the accept cycle; unsync_bus=0xA5 one cycle later.
  - bus_enable high for 3 cycles starting 2 cycles after accept, then low 3 cycles; busy high for 7 cycles after the accept edge.
- Contention, RR: both valid continuously, data 0x11/0x22.
  - Accepts alternate 0,1,0,1; each accept spaced 8 cycles apart; grant_id follows.
  - Without the macro, requester 0 wins every time.
- Back-to-back, HOLD=1 GAP=1: continuous valid on requester 1.
  - bus_enable pattern 0,0,1,0 repeating; a new word is accepted every 4 cycles; unsync_bus never changes while bus_enable=1 or during GAP.
- Reset mid-HOLD: assert RST low while bus_enable=1.
  - bus_enable, unsync_bus and busy go to 0 immediately (asynchronously).
  - After release, the first grant goes to requester 0 and sequencing restarts cleanly from IDLE.
- Valid withdrawn: req_valid[1] pulses only during requester 0's HOLD.
  - No accept occurs for requester 1; pointer unchanged; the next grant depends only on valids present in IDLE.
- End-to-end: scheduler driving the synchronizer with N=2 in the same clock.
  - Destination enable_pulse fires exactly once per word, and sync_bus matches each captured word in order.
